// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: accepts an op and a count on start, then shifts
// one bit per enabled cycle, pulsing done once the count is exhausted.
module seq_shift_unit #(
    parameter int N = 32,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] amt,
    input  logic [N-1:0]  din,
    input  logic          sin,
    input  logic          en,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_SRI  = 3'b110;
    localparam logic [2:0] OP_SLI  = 3'b111;

    logic [1:0]    state;
    logic [2:0]    op_r;
    logic [AW-1:0] count;
    logic [N-1:0]  step_q;
    logic          step_out;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // One 1-bit step of the latched op; step_out is the bit leaving the register.
    always_comb begin
        step_q   = q;
        step_out = sout;
        case (op_r)
            OP_SRL: begin step_q = {1'b0, q[N-1:1]};    step_out = q[0];   end
            OP_SLL: begin step_q = {q[N-2:0], 1'b0};    step_out = q[N-1]; end
            OP_SRA: begin step_q = {q[N-1], q[N-1:1]};  step_out = q[0];   end
            OP_ROR: begin step_q = {q[0], q[N-1:1]};    step_out = q[0];   end
            OP_ROL: begin step_q = {q[N-2:0], q[N-1]};  step_out = q[N-1]; end
            OP_SRI: begin step_q = {sin, q[N-1:1]};     step_out = q[0];   end
            OP_SLI: begin step_q = {q[N-2:0], sin};     step_out = q[N-1]; end
            default: begin step_q = q;                  step_out = sout;   end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            op_r  <= OP_LOAD;
            count <= '0;
            q     <= '0;
            sout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        count <= amt;
                        if (op == OP_LOAD) begin
                            q     <= din;
                            state <= DONE;
                        end else if (amt == '0) begin
                            state <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (en) begin
                        q     <= step_q;
                        sout  <= step_out;
                        count <= count - 1'b1;
                        if (count == AW'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
